enfreq_sched: RTL and testbench
===============================

Name: enfreq_sched

Overview:
Multi-channel clock-enable scheduler that sequences the team's enable-frequency generation. It holds a programmable period per channel and emits phase-aligned single-cycle enable pulses (tick) to downstream logic. A run/stop state machine controls it, and a valid/ready config port writes the channel periods. Period changes take effect glitch-free at each channel's period boundary.

Parameters:
N_CH, 4, number of enable channels (1..8)
DIV_W, 16, width of the period field and the per-channel counter
DEF_DIV, 100, period loaded into every channel at reset (must be less than 2**DIV_W)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin ticking
stop  in  1  one-cycle request to halt ticking
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid and cfg_ready are both high
cfg_ch  in  $clog2(N_CH) (min 1)  target channel
cfg_div  in  DIV_W  new period in cycles; 0 disables the channel
tick  out  N_CH  one-cycle enable pulses, one bit per channel, registered
running  out  1  high while in RUN, registered
tick0_cnt  out  32  count of channel-0 ticks since last start, wraps at 2**32

Behaviour:
- Reset: state=IDLE; tick=0; running=0; cfg_ready=1; tick0_cnt=0; shadow[i]=active[i]=DEF_DIV; counters=0.
- FSM states: IDLE, SYNC, RUN.
  - IDLE -> SYNC on start.
  - SYNC lasts exactly 1 cycle: load active[i]=shadow[i] for all i, clear all counters, clear tick0_cnt. SYNC -> RUN unconditionally, unless stop is high, in which case SYNC -> IDLE.
  - RUN -> IDLE on stop.
  - start while in RUN or SYNC is ignored.
  - start and stop in the same cycle: stop wins, and the state stays at or goes to IDLE.
- running: 1 in every RUN cycle, 0 otherwise. It rises on the clock after SYNC.
- Channel counting in RUN:
  - Counter i increments each cycle.
  - When counter i = active[i]-1, the counter wraps to 0 and tick[i] is 1 in the next cycle.
  - With cycle 1 as the first cycle running=1, tick[i] is high in cycles active[i], 2*active[i], and so on.
  - active[i]=1 gives tick[i]=1 every RUN cycle starting at cycle 1.
  - active[i]=0 holds tick[i]=0 and the counter at 0.
- Config writes:
  - An accepted write updates shadow[cfg_ch] on that edge.
  - In IDLE, shadow is copied to active at the next SYNC.
  - In RUN, active[i] is reloaded from shadow[i] on the wrap edge of channel i. A write that lands on the same edge as a wrap takes effect at the following wrap.
  - If active[i] is 0 (channel disabled) in RUN, shadow is loaded into active on the next cycle and the counter restarts from 0.
  - cfg_ready=0 only in SYNC; writes offered in SYNC are stalled, not dropped.
  - cfg_ch >= N_CH: the write is accepted and discarded.
- Stop mid-period: tick is forced to 0 from the first IDLE cycle. Counters are frozen and are cleared at the next SYNC. No partial tick is issued.
- tick0_cnt increments by 1 in the cycle tick[0]=1. It holds its value in IDLE.
- Asynchronous rst mid-RUN: all outputs return to reset values immediately; shadow values revert to DEF_DIV.

Decomposition:
- Package enfreq_pkg: state encoding constants (IDLE, SYNC, RUN), the DEF_DIV default, and the width helper for cfg_ch.
- One sub-module, enfreq_div_chan, instantiated N_CH times. Inputs: clk, rst, clr, run, shadow, load_req. Outputs: tick and wrap. It holds its active register and counter and applies the reload-at-wrap rule.
- The FSM, config decode and tick0_cnt live in the top level.

Test Plan:
- Reset, write ch0=4 and ch1=1 in IDLE, pulse start -> running rises 2 edges after start; tick[0] high in RUN cycles 4, 8, 12; tick[1] high every RUN cycle; tick0_cnt=3 after 12 RUN cycles.
- In RUN with ch0=4, write ch0=2 during cycle 2 -> next tick at cycle 4, then ticks at 6, 8, 10.
- Write ch2=0 in RUN -> tick[2] stays 0 from its next wrap onward; later write ch2=3 -> tick[2] resumes, first pulse 3 cycles after reload.
- start and stop asserted together in IDLE -> state stays IDLE, running=0, no ticks. Stop in RUN at cycle 6 with ch0=4 -> no tick at cycle 8. Restart -> tick0_cnt cleared, first tick at cycle 4.
- cfg_valid held across SYNC -> cfg_ready=0 for exactly 1 cycle; write accepted the next cycle. cfg_ch=7 with N_CH=4 -> accepted with no effect on any channel.
- Assert rst asynchronously between clock edges mid-RUN -> tick, running and tick0_cnt go to 0 before the next edge; after release, shadow values equal DEF_DIV=100.

Source files
------------

// File: rtl/enfreq_pkg.sv
// Shared definitions for the enable-frequency scheduler: FSM encoding,
// the reset period and the width helper for the channel-select field.
package enfreq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   // Period loaded into every channel (shadow and active) at reset.
   localparam int unsigned DEF_DIV_RST = 100;

   // Width of a channel index; a single channel still gets a 1-bit select.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/enfreq_div_chan.sv
// One divider channel: holds the active period and a free-running counter,
// emits a registered tick one cycle after the counter wraps, and reloads its
// period from the shadow value on every wrap edge (or at once if disabled).
module enfreq_div_chan
   import enfreq_pkg::*;
#(
   parameter int          DIV_W   = 16,
   parameter int unsigned DEF_DIV = DEF_DIV_RST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             run,
   input  logic             load_req,
   input  logic [DIV_W-1:0] shadow,
   output logic             tick,
   output logic             wrap
);

   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);

   logic [DIV_W-1:0] active_q, active_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] eff_active, eff_cnt;
   logic             fresh;
   logic             tick_q, tick_d;

   // Counting and reload decision for the coming edge.
   // A "fresh" edge (sync load, or a disabled channel picking up its shadow)
   // behaves as count 0 of the newly loaded period, so that edge already counts.
   always_comb begin
      fresh      = clr | load_req | (active_q == '0);
      eff_active = fresh ? shadow : active_q;
      eff_cnt    = fresh ? '0 : cnt_q;
      wrap       = run && (eff_active != '0) && (eff_cnt == eff_active - ONE);
      active_d   = active_q;
      cnt_d      = cnt_q;
      tick_d     = wrap;
      if (run) begin
         if (wrap) begin
            active_d = shadow;
            cnt_d    = '0;
         end else if (eff_active == '0) begin
            active_d = eff_active;
            cnt_d    = '0;
         end else begin
            active_d = eff_active;
            cnt_d    = eff_cnt + ONE;
         end
      end else if (clr | load_req) begin
         active_d = shadow;
         cnt_d    = '0;
      end
   end

   // Period, counter and tick registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= RST_DIV;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/enfreq_sched.sv
// Multi-channel clock-enable scheduler: run/stop FSM, config write port for
// per-channel shadow periods, N_CH divider channels and a channel-0 tick count.
module enfreq_sched
   import enfreq_pkg::*;
#(
   parameter int          N_CH    = 4,
   parameter int          DIV_W   = 16,
   parameter int unsigned DEF_DIV = DEF_DIV_RST,
   localparam int         CH_W    = ch_w(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   output logic [N_CH-1:0]  tick,
   output logic             running,
   output logic [31:0]      tick0_cnt
);

   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);

   state_e           state_q, state_d;
   logic             running_q, cfg_ready_q;
   logic [31:0]      cnt_q, cnt_d;
   logic [DIV_W-1:0] shadow_q [N_CH];
   logic             sync, chan_run, cfg_acc;
   logic [N_CH-1:0]  wrap_w;
   logic             unused_wrap_hi;

   // Next state, channel control strobes and the next tick-0 count.
   // Stop always wins; channels run on every edge whose next state is RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && !stop) state_d = ST_SYNC;
         ST_SYNC: state_d = stop ? ST_IDLE : ST_RUN;
         ST_RUN:  if (stop) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      sync     = (state_q == ST_SYNC);
      chan_run = (state_d == ST_RUN);
      cfg_acc  = cfg_valid && cfg_ready_q;
      cnt_d    = (sync ? 32'd0 : cnt_q) + {31'd0, wrap_w[0]};
   end

   // FSM state and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         running_q   <= 1'b0;
         cfg_ready_q <= 1'b1;
         cnt_q       <= 32'd0;
      end else begin
         state_q     <= state_d;
         running_q   <= (state_d == ST_RUN);
         cfg_ready_q <= (state_d != ST_SYNC);
         cnt_q       <= cnt_d;
      end
   end

   // Shadow periods; writes to a channel index that does not exist are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) shadow_q[i] <= RST_DIV;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (cfg_acc && (int'(cfg_ch) == i)) shadow_q[i] <= cfg_div;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_chan
      enfreq_div_chan #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .clr      (sync),
         .run      (chan_run),
         .load_req (sync),
         .shadow   (shadow_q[g]),
         .tick     (tick[g]),
         .wrap     (wrap_w[g])
      );
   end

   // Only channel 0's wrap strobe has a consumer here (the tick-0 count).
   assign unused_wrap_hi = ^wrap_w;

   assign cfg_ready = cfg_ready_q;
   assign running   = running_q;
   assign tick0_cnt = cnt_q;

endmodule

// File: tb/tb_enfreq_sched.sv
// Testbench for enfreq_sched: directed scenarios followed by random traffic,
// predicted by a due-time schedule model and checked through a scoreboard.
module tb_enfreq_sched;

   localparam int N_CH  = 5;
   localparam int DIV_W = 16;
   localparam int DEFD  = 100;
   localparam int CH_W  = 3;

   logic             clk, rst, start, stop, cfg_valid, cfg_ready, running;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic [N_CH-1:0]  tick;
   logic [31:0]      tick0_cnt;

   enfreq_sched #(.N_CH(N_CH), .DIV_W(DIV_W), .DEF_DIV(DEFD)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .tick      (tick),
      .running   (running),
      .tick0_cnt (tick0_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N_CH-1:0] tick;
      logic            running;
      logic [31:0]     cnt;
      logic            ready;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model: schedule of absolute tick cycles per channel.
   int          m_state;            // 0 idle, 1 sync, 2 run
   int unsigned m_sh  [N_CH];
   int unsigned m_act [N_CH];
   int unsigned m_due [N_CH];
   int unsigned m_cyc;
   logic [31:0] m_cnt;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
   endfunction

   function automatic void model_reset();
      m_state = 0;
      m_cyc   = 0;
      m_cnt   = 0;
      for (int i = 0; i < N_CH; i++) begin
         m_sh[i]  = DEFD;
         m_act[i] = DEFD;
         m_due[i] = 0;
      end
   endfunction

   // Predict the outputs after the coming edge from the current inputs.
   function automatic void model_edge(output bit acc, output exp_t e);
      int unsigned     old_sh [N_CH];
      int              nxt;
      logic [N_CH-1:0] tk;
      old_sh = m_sh;
      acc = cfg_valid && (m_state != 1);
      if (acc && (int'(cfg_ch) < N_CH)) m_sh[cfg_ch] = int'(cfg_div);
      nxt = m_state;
      if (stop) nxt = 0;
      else if (m_state == 0 && start) nxt = 1;
      else if (m_state == 1) nxt = 2;
      tk = '0;
      if (m_state == 1) begin
         m_cyc = 0;
         m_cnt = 0;
         for (int i = 0; i < N_CH; i++) begin
            m_act[i] = old_sh[i];
            m_due[i] = m_act[i];
         end
      end
      if (nxt == 2) begin
         for (int i = 0; i < N_CH; i++) begin
            if (m_state == 2 && m_act[i] == 0) begin
               m_act[i] = old_sh[i];
               m_due[i] = m_cyc + m_act[i];
            end
            if (m_act[i] != 0 && m_due[i] == m_cyc + 1) begin
               tk[i]    = 1'b1;
               m_act[i] = old_sh[i];
               m_due[i] = m_cyc + 1 + m_act[i];
            end
         end
         m_cyc++;
         if (tk[0]) m_cnt++;
      end
      m_state   = nxt;
      e.tick    = tk;
      e.running = (nxt == 2);
      e.cnt     = m_cnt;
      e.ready   = (nxt != 1);
   endfunction

   task automatic step(input logic st, input logic sp);
      bit   acc;
      exp_t e;
      start = st;
      stop  = sp;
      model_edge(acc, e);
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      if (acc) cfg_valid = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0);
   endtask

   task automatic wr(input int ch, input int dv);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = DIV_W'(dv);
      for (int k = 0; k < 4 && cfg_valid; k++) step(1'b0, 1'b0);
      if (cfg_valid) begin
         chk("cfg_accept_timeout", 32'(cfg_valid), 32'd0);
         cfg_valid = 1'b0;
      end
   endtask

   // Scoreboard monitor: compare each predicted cycle mid-period.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("tick",      32'(tick),      32'(e.tick));
         chk("running",   32'(running),   32'(e.running));
         chk("tick0_cnt", tick0_cnt,      e.cnt);
         chk("cfg_ready", 32'(cfg_ready), 32'(e.ready));
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tick",    32'(tick),      32'd0);
      chk("rst_running", 32'(running),   32'd0);
      chk("rst_cnt",     tick0_cnt,      32'd0);
      chk("rst_ready",   32'(cfg_ready), 32'd1);
      rst = 1'b0;
      idle(2);

      // Program periods in IDLE, then run: ch0 every 4, ch1 every cycle.
      wr(0, 4); wr(1, 1); wr(2, 5); wr(3, 2); wr(4, 0);
      step(1'b1, 1'b0); idle(14);
      step(1'b0, 1'b1); idle(2);

      // start and stop together in IDLE.
      step(1'b1, 1'b1); idle(3);

      // Period change ch0 4 -> 2 written during RUN cycle 2.
      step(1'b1, 1'b0); idle(2);
      wr(0, 2); idle(10);

      // Disable ch2, then re-enable with period 3.
      wr(2, 0); idle(12);
      wr(2, 3); idle(10);
      step(1'b0, 1'b1);

      // Stop at RUN cycle 6 with ch0=4, then restart.
      wr(0, 4);
      step(1'b1, 1'b0); idle(6);
      step(1'b0, 1'b1); idle(4);

      // Config offered during SYNC is stalled one cycle; out-of-range channel.
      step(1'b1, 1'b0);
      cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd2;
      idle(8);
      wr(7, 1); idle(6);

      // Asynchronous reset between edges mid-RUN.
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("arst_tick",    32'(tick),      32'd0);
      chk("arst_running", 32'(running),   32'd0);
      chk("arst_cnt",     tick0_cnt,      32'd0);
      chk("arst_ready",   32'(cfg_ready), 32'd1);
      model_reset();
      cfg_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Shadow reverted to the default period: all channels tick at cycle 100.
      step(1'b1, 1'b0); idle(105);
      step(1'b0, 1'b1); idle(2);

      // Random traffic.
      for (int k = 0; k < 1500; k++) begin
         if (!cfg_valid && ($urandom % 4 == 0)) begin
            cfg_valid = 1'b1;
            cfg_ch    = CH_W'($urandom_range(0, 7));
            cfg_div   = DIV_W'($urandom_range(0, 6));
         end
         step(($urandom % 20) == 0, ($urandom % 40) == 0);
      end

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
